// File: rtl/fc_vector_tx.sv
// fc_vector_tx: host-loaded N-word buffer streamed word 0 first on valid/ready.
// Optional FC_VECTOR_TX_RELU_EN clamps negative words to zero as they are sent.
module fc_vector_tx #(
  parameter  int N         = 9,
  parameter  int WIDTH     = 14,
  localparam int ADDR_SIZE = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_SIZE-1:0]    wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    start,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [WIDTH-1:0] output_data,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_dropped
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(N - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE + 1)'(N);

  state_e                  state_q, state_d;
  logic [ADDR_SIZE-1:0]    idx_q, idx_d;
  logic [ADDR_SIZE-1:0]    idx_nxt;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    drop_q, drop_d;
  logic                    xfer;
  logic                    buf_we;
  logic signed [WIDTH-1:0] buf_q [N];

  // Word as it goes on the wire; the buffer itself is never modified.
  function automatic logic signed [WIDTH-1:0] send_word(
    input logic signed [WIDTH-1:0] w
  );
`ifdef FC_VECTOR_TX_RELU_EN
    return w[WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign xfer    = valid_q && output_ready;
  assign idx_nxt = idx_q + ADDR_SIZE'(1);

  // Next-state: start beats a same-cycle write; writes only land in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = send_word(buf_q[0]);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          drop_d  = wr_en;
        end else if (wr_en) begin
          if ({1'b0, wr_addr} < DEPTH) begin
            buf_we = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      SEND: begin
        drop_d = wr_en;
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            data_d = send_word(buf_q[idx_nxt]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any stream at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Vector storage: no reset, contents survive a stream abort.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  assign output_valid = valid_q;
  assign output_data  = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_dropped   = drop_q;

endmodule

// File: tb/tb_fc_vector_tx.sv
// tb_fc_vector_tx: scoreboard bench for fc_vector_tx.
// Expected words queued at start, popped on each valid&&ready transfer.
module tb_fc_vector_tx;

  localparam int N     = 9;
  localparam int WIDTH = 14;
  localparam int AW    = $clog2(N);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic signed [WIDTH-1:0] wr_data;
  logic                    start;
  logic                    output_valid;
  logic                    ready;
  logic signed [WIDTH-1:0] output_data;
  logic                    busy;
  logic                    done;
  logic                    wr_dropped;

  int checks = 0;
  int errors = 0;
  int vec [N];
  logic signed [WIDTH-1:0] q [$];

  fc_vector_tx #(
    .N(N),
    .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .output_valid(output_valid),
    .output_ready(ready),
    .output_data(output_data),
    .busy(busy),
    .done(done),
    .wr_dropped(wr_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [WIDTH-1:0] expw(input int v);
    logic signed [WIDTH-1:0] w;
    w = WIDTH'(v);
`ifdef FC_VECTOR_TX_RELU_EN
    if (w < 0) w = '0;
`endif
    return w;
  endfunction

  function automatic logic pick(input int mode, input int c);
    if (mode == 1) return (c % 3) == 0;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic write_word(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = WIDTH'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_vec();
    for (int i = 0; i < N; i++) write_word(i, vec[i]);
  endtask

  task automatic kick(input bit with_wr);
    for (int i = 0; i < N; i++) q.push_back(expw(vec[i]));
    start   = 1'b1;
    wr_en   = with_wr;
    wr_addr = '0;
    wr_data = WIDTH'(100);
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // Scoreboard drain: pops one expected word per transfer, checks hold on stall.
  task automatic run_stream(
    input  string tag,
    input  int    mode,
    input  int    drop_at,
    input  int    stop_after,
    input  bit    again,
    output int    first,
    output int    last,
    output int    nx,
    output int    busy_cnt,
    output int    done_cnt,
    output int    done_c,
    output int    drop_cnt,
    output int    drop_c
  );
    logic signed [WIDTH-1:0] ew;
    logic signed [WIDTH-1:0] held;
    bit stall;
    bit restarted;
    bit stopped;
    int target;
    first = -1; last = -1; nx = 0; busy_cnt = 0;
    done_cnt = 0; done_c = -1; drop_cnt = 0; drop_c = -1;
    stall = 1'b0; held = '0; restarted = 1'b0; stopped = 1'b0;
    target = again ? 2 : 1;
    ready = pick(mode, 0);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_c = c; end
      if (wr_dropped) begin drop_cnt++; drop_c = c; end
      if (stall) begin
        checks++;
        if (!output_valid || output_data !== held) begin
          errors++;
          $display("FAIL %s hold c=%0d: valid=%0b data=%0d, required valid=1 data=%0d",
                   tag, c, output_valid, output_data, held);
        end
      end
      stall = output_valid && !ready;
      held  = output_data;
      if (output_valid && ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s extra word c=%0d: data=%0d, required no word",
                   tag, c, output_data);
        end else begin
          ew = q.pop_front();
          if (output_data !== ew) begin
            errors++;
            $display("FAIL %s word %0d: data=%0d, required %0d",
                     tag, nx, output_data, ew);
          end
        end
        if (first < 0) first = c;
        last = c;
        nx++;
      end
      if (stop_after > 0 && nx == stop_after) begin
        stopped = 1'b1;
        break;
      end
      if (done_cnt >= target && q.size() == 0 && c > done_c) break;
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (again && done && !restarted) begin
        restarted = 1'b1;
        for (int i = 0; i < N; i++) q.push_back(expw(vec[i]));
        start = 1'b1;
      end
      if (c == drop_at) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = WIDTH'(100);
      end
      ready = pick(mode, c + 1);
    end
    if (!stopped) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL %s timeout: %0d words left, required 0", tag, q.size());
      end
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b0) begin
      errors++; $display("FAIL reset valid: %0b, required 0", output_valid);
    end
    checks++;
    if (output_data !== '0) begin
      errors++; $display("FAIL reset data: %0d, required 0", output_data);
    end
    checks++;
    if ({busy, done, wr_dropped} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: busy/done/drop=%b, required 000",
               {busy, done, wr_dropped});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({output_valid, busy, done, wr_dropped} !== 4'b0 || output_data !== '0) begin
        errors++;
        $display("FAIL idle c=%0d: v/b/d/w=%b data=%0d, required 0000 data=0",
                 c, {output_valid, busy, done, wr_dropped}, output_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    int f, l, nx, bc, dc, dcy, wc, wcy;
    for (int i = 0; i < N; i++) vec[i] = i + 1;
    load_vec();
    ready = 1'b1;
    kick(1'b0);
    run_stream("stream", 0, -1, 0, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (f != 0 || l != N - 1 || nx != N) begin
      errors++;
      $display("FAIL stream timing: first=%0d last=%0d n=%0d, required 0 %0d %0d",
               f, l, nx, N - 1, N);
    end
    checks++;
    if (dc != 1 || dcy != l + 1) begin
      errors++;
      $display("FAIL stream done: count=%0d cycle=%0d, required 1 at %0d",
               dc, dcy, l + 1);
    end
    checks++;
    if (bc != N) begin
      errors++; $display("FAIL stream busy: %0d cycles, required %0d", bc, N);
    end
  endtask

  task automatic test_backpressure();
    int f, l, nx, bc, dc, dcy, wc, wcy;
    kick(1'b0);
    run_stream("bp", 1, -1, 0, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (nx != N || dc != 1 || dcy != l + 1) begin
      errors++;
      $display("FAIL bp totals: n=%0d done=%0d@%0d, required %0d 1@%0d",
               nx, dc, dcy, N, l + 1);
    end
  endtask

  task automatic test_drops();
    int f, l, nx, bc, dc, dcy, wc, wcy;
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = WIDTH'(55);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_dropped !== 1'b1) begin
      errors++; $display("FAIL drop addr9: wr_dropped=%0b, required 1", wr_dropped);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wr_dropped !== 1'b0) begin
      errors++; $display("FAIL drop pulse: wr_dropped=%0b, required 0", wr_dropped);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    kick(1'b1);
    run_stream("drop", 0, 2, 0, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (wc != 2 || wcy != 4) begin
      errors++;
      $display("FAIL drop send: count=%0d last=%0d, required 2 last=4", wc, wcy);
    end
    kick(1'b0);
    run_stream("drop2", 0, -1, 0, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (nx != N || wc != 0) begin
      errors++;
      $display("FAIL drop2: n=%0d drops=%0d, required %0d 0", nx, wc, N);
    end
  endtask

  task automatic test_relu();
    int f, l, nx, bc, dc, dcy, wc, wcy;
    vec[0] = -5; vec[1] = 3;  vec[2] = -1; vec[3] = 7;     vec[4] = -8;
    vec[5] = 0;  vec[6] = 2;  vec[7] = -8192; vec[8] = 8191;
    load_vec();
    kick(1'b0);
    run_stream("relu", 2, -1, 0, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (nx != N || dc != 1) begin
      errors++; $display("FAIL relu totals: n=%0d done=%0d, required %0d 1", nx, dc, N);
    end
  endtask

  task automatic test_reset_mid();
    int f, l, nx, bc, dc, dcy, wc, wcy;
    for (int i = 0; i < N; i++) vec[i] = i + 1;
    load_vec();
    kick(1'b0);
    run_stream("mid", 0, -1, 4, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (output_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid abort: valid=%0b busy=%0b, required 0 0", output_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mid done: %0b, required 0", done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    kick(1'b0);
    run_stream("restart", 0, -1, 0, 1'b0, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (f != 0 || nx != N || dc != 1) begin
      errors++;
      $display("FAIL restart: first=%0d n=%0d done=%0d, required 0 %0d 1", f, nx, dc, N);
    end
  endtask

  task automatic test_back_to_back();
    int f, l, nx, bc, dc, dcy, wc, wcy;
    kick(1'b0);
    run_stream("b2b", 0, -1, 0, 1'b1, f, l, nx, bc, dc, dcy, wc, wcy);
    checks++;
    if (nx != 2 * N || l != 2 * N || dc != 2 || bc != 2 * N) begin
      errors++;
      $display("FAIL b2b: n=%0d last=%0d done=%0d busy=%0d, required %0d %0d 2 %0d",
               nx, l, dc, bc, 2 * N, 2 * N, 2 * N);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drops();
    test_relu();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
